// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: MDOp encodings, default latencies
// and the long-op decode the hazard unit reuses. MDU_MADD_EN enables the madd/msub group.
package mdu_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8,
        MD_MADD  = 4'd9,
        MD_MADDU = 4'd10,
        MD_MSUB  = 4'd11,
        MD_MSUBU = 4'd12
    } mdop_e;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_e;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;
    localparam int MDU_CNT_W       = 8;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Ops that occupy the unit for several cycles and must be started with `start`.
    function automatic logic is_long_op(input logic [3:0] op);
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mdu_busy_counter.sv
// Loadable down-counter that times a long op; `done` flags the final busy cycle
// so the parent can commit HI/LO on the edge that ends it.
module mdu_busy_counter
    import mdu_pkg::*;
#(
    parameter int CNT_W = MDU_CNT_W
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             count,
    output logic             busy,
    output logic             done
);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             busy_reg, busy_next;

    always_comb begin
        cnt_next  = cnt_reg;
        busy_next = busy_reg;
        if (load) begin
            cnt_next  = load_val;
            busy_next = (load_val != '0);
        end else if (count && busy_reg) begin
            cnt_next  = cnt_reg - CNT_W'(1);
            busy_next = (cnt_reg != CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            busy_reg <= busy_next;
        end
    end

    assign busy = busy_reg;
    assign done = busy_reg && count && (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit owning HI/LO; long ops run for a fixed latency.
// Optional feature: define MDU_MADD_EN for madd/maddu/msub/msubu accumulate ops.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDOp,
    input  logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] out
);

    localparam logic [MDU_CNT_W-1:0] MULT_LAT = MDU_CNT_W'(MULT_CYCLES);
    localparam logic [MDU_CNT_W-1:0] DIV_LAT  = MDU_CNT_W'(DIV_CYCLES);

    mdu_state_e  state_reg, state_next;
    logic        launch;
    logic        done;
    logic [31:0] a_reg, b_reg;
    logic [3:0]  op_reg;
    logic [31:0] hi_reg, lo_reg, hi_next, lo_next;
    logic        wr_hi, wr_lo;

    logic        prod_signed;
    logic [63:0] a_wide, b_wide, prod;
    logic signed [31:0] quot_s, rem_s;
    logic [31:0] quot_u, rem_u;

`ifdef MDU_MADD_EN
    logic [63:0] acc_reg;
`endif

    always_comb begin
        state_next = state_reg;
        launch     = 1'b0;
        case (state_reg)
            MDU_IDLE: begin
                if (start && is_long_op(MDOp)) begin
                    launch     = 1'b1;
                    state_next = MDU_RUN;
                end
            end
            MDU_RUN: begin
                if (done) state_next = MDU_IDLE;
            end
            default: state_next = MDU_IDLE;
        endcase
    end

    mdu_busy_counter #(
        .CNT_W(MDU_CNT_W)
    ) u_busy_counter (
        .clk     (clk),
        .srst    (reset),
        .load    (launch),
        .load_val(is_div_op(MDOp) ? DIV_LAT : MULT_LAT),
        .count   (state_reg == MDU_RUN),
        .busy    (busy),
        .done    (done)
    );

    // A 64-bit product of sign- or zero-extended operands is the exact 64-bit result either way.
    always_comb begin
        prod_signed = (op_reg == MD_MULT) || (op_reg == MD_MADD) || (op_reg == MD_MSUB);
        a_wide      = prod_signed ? {{32{a_reg[31]}}, a_reg} : {32'h0, a_reg};
        b_wide      = prod_signed ? {{32{b_reg[31]}}, b_reg} : {32'h0, b_reg};
        prod        = a_wide * b_wide;
        quot_s      = $signed(a_reg) / $signed(b_reg);
        rem_s       = $signed(a_reg) % $signed(b_reg);
        quot_u      = a_reg / b_reg;
        rem_u       = a_reg % b_reg;
    end

    always_comb begin
        hi_next = hi_reg;
        lo_next = lo_reg;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        if (done) begin
            case (op_reg)
                MD_MULT, MD_MULTU: begin
                    {hi_next, lo_next} = prod;
                    wr_hi = 1'b1;
                    wr_lo = 1'b1;
                end
                MD_DIV: begin
                    hi_next = rem_s;
                    lo_next = quot_s;
                    wr_hi   = (b_reg != '0);
                    wr_lo   = (b_reg != '0);
                end
                MD_DIVU: begin
                    hi_next = rem_u;
                    lo_next = quot_u;
                    wr_hi   = (b_reg != '0);
                    wr_lo   = (b_reg != '0);
                end
`ifdef MDU_MADD_EN
                MD_MADD, MD_MADDU: begin
                    {hi_next, lo_next} = acc_reg + prod;
                    wr_hi = 1'b1;
                    wr_lo = 1'b1;
                end
                MD_MSUB, MD_MSUBU: begin
                    {hi_next, lo_next} = acc_reg - prod;
                    wr_hi = 1'b1;
                    wr_lo = 1'b1;
                end
`endif
                default: ;
            endcase
        end else if (state_reg == MDU_IDLE) begin
            if (MDOp == MD_MTHI) begin
                hi_next = A;
                wr_hi   = 1'b1;
            end
            if (MDOp == MD_MTLO) begin
                lo_next = A;
                wr_lo   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= MDU_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= MD_NONE;
            hi_reg    <= '0;
            lo_reg    <= '0;
`ifdef MDU_MADD_EN
            acc_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;
            if (launch) begin
                a_reg  <= A;
                b_reg  <= B;
                op_reg <= MDOp;
`ifdef MDU_MADD_EN
                acc_reg <= {hi_reg, lo_reg};
`endif
            end
            if (wr_hi) hi_reg <= hi_next;
            if (wr_lo) lo_reg <= lo_next;
        end
    end

    assign HI  = hi_reg;
    assign LO  = lo_reg;
    assign out = (MDOp == MD_MFHI) ? hi_reg : lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO/latency queued at launch,
// popped and compared when busy falls. Define MDU_MADD_EN to cover accumulate ops.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic [3:0]  MDOp;
    logic        start;
    logic        busy;
    logic [31:0] HI, LO, out;

    typedef struct {
        int          cycles;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mult_div_unit dut (
        .clk  (clk),
        .reset(reset),
        .A    (A),
        .B    (B),
        .MDOp (MDOp),
        .start(start),
        .busy (busy),
        .HI   (HI),
        .LO   (LO),
        .out  (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end else begin
            $display("ok   %s: %0h", tag, act);
        end
    endtask

    // Called between edges; updates the reference HI/LO and queues the expectation.
    task automatic do_launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        int          ia, ib;
        longint      sa, sb;
        logic [63:0] p;
        ia = a;
        ib = b;
        sa = ia;
        sb = ib;
        case (op)
            4'd1: {m_hi, m_lo} = sa * sb;
            4'd2: {m_hi, m_lo} = {32'h0, a} * {32'h0, b};
            4'd3: if (b != 0) begin m_lo = ia / ib; m_hi = ia % ib; end
            4'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
`ifdef MDU_MADD_EN
            4'd9, 4'd11: begin
                p = sa * sb;
                {m_hi, m_lo} = (op == 4'd9) ? {m_hi, m_lo} + p : {m_hi, m_lo} - p;
            end
            4'd10, 4'd12: begin
                p = {32'h0, a} * {32'h0, b};
                {m_hi, m_lo} = (op == 4'd10) ? {m_hi, m_lo} + p : {m_hi, m_lo} - p;
            end
`endif
            default: p = '0;
        endcase
        e.cycles = (op == 4'd3 || op == 4'd4) ? 10 : 5;
        e.hi     = m_hi;
        e.lo     = m_lo;
        sb_q.push_back(e);
        MDOp  = op;
        A     = a;
        B     = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        MDOp  = 4'd0;
        A     = $urandom;
        B     = $urandom;
    endtask

    task automatic wait_done(input string tag, input bit poke_mtlo);
        exp_t e;
        int   cnt = 0;
        forever begin
            @(negedge clk);
            if (!busy || cnt > 40) break;
            cnt++;
            if (poke_mtlo && cnt == 1) begin MDOp = 4'd8; A = 32'hDEADBEEF; end
            if (poke_mtlo && cnt == 2) MDOp = 4'd0;
        end
        chk({tag, "_sbq_size"}, sb_q.size(), 1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        chk({tag, "_busy_cycles"}, cnt, e.cycles);
        chk({tag, "_hi"}, HI, e.hi);
        chk({tag, "_lo"}, LO, e.lo);
    endtask

    task automatic mt_write(input logic [3:0] op, input logic [31:0] val);
        MDOp = op;
        A    = val;
        @(posedge clk);
        #1;
        MDOp = 4'd0;
        if (op == 4'd7) m_hi = val; else m_lo = val;
        @(negedge clk);
        chk(op == 4'd7 ? "mthi_hi" : "mtlo_lo", op == 4'd7 ? HI : LO, val);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        MDOp  = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_hi", HI, 0);
        chk("rst_lo", LO, 0);
        chk("rst_out", out, 0);
        reset = 1'b0;
        @(negedge clk);

        do_launch(4'd1, 32'hFFFFFFFE, 32'd3);
        wait_done("mult", 1'b0);
        chk("mult_hi_const", HI, 32'hFFFFFFFF);
        chk("mult_lo_const", LO, 32'hFFFFFFFA);

        do_launch(4'd2, 32'hFFFFFFFE, 32'd3);
        wait_done("multu", 1'b0);
        chk("multu_hi_const", HI, 32'h00000002);

        do_launch(4'd3, 32'hFFFFFFF9, 32'd2);
        wait_done("div", 1'b0);
        chk("div_lo_const", LO, 32'hFFFFFFFD);
        chk("div_hi_const", HI, 32'hFFFFFFFF);

        // Divide by zero with an MTLO attempt while busy: LO must stay as it was.
        do_launch(4'd4, 32'd7, 32'd0);
        wait_done("divu_by0", 1'b1);

        for (int i = 0; i < 6; i++) begin
            do_launch(4'($urandom_range(1, 4)), $urandom,
                      (i % 2 == 1) ? 32'($urandom_range(1, 9)) : $urandom);
            wait_done("rand", 1'b0);
        end

        mt_write(4'd7, 32'h12345678);
        mt_write(4'd8, 32'h9ABCDEF0);
        MDOp = 4'd5;
        #1;
        chk("mfhi_out", out, m_hi);
        MDOp = 4'd6;
        #1;
        chk("mflo_out", out, m_lo);

        // start with a short op must not occupy the unit
        @(negedge clk);
        MDOp  = 4'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        MDOp  = 4'd0;
        chk("start_short_busy", busy, 0);

        // reset and start on the same edge: reset wins
        reset = 1'b1;
        start = 1'b1;
        MDOp  = 4'd1;
        A     = 32'd9;
        B     = 32'd9;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        MDOp  = 4'd0;
        m_hi  = '0;
        m_lo  = '0;
        chk("rst_start_busy", busy, 0);
        @(negedge clk);
        chk("rst_start_busy_later", busy, 0);

        // reset in cycle 3 of a divide aborts it with no late write
        do_launch(4'd3, 32'd100, 32'd7);
        void'(sb_q.pop_back());
        m_hi = '0;
        m_lo = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_hi", HI, 0);
        chk("abort_lo", LO, 0);
        repeat (12) @(negedge clk);
        chk("abort_late_hi", HI, 0);
        chk("abort_late_lo", LO, 0);

`ifdef MDU_MADD_EN
        mt_write(4'd7, 32'h0);
        mt_write(4'd8, 32'hFFFFFFFF);
        do_launch(4'd10, 32'd1, 32'd1);
        wait_done("maddu", 1'b0);
        chk("maddu_hi_const", HI, 32'd1);
        chk("maddu_lo_const", LO, 32'd0);
        do_launch(4'd11, 32'hFFFFFFFD, 32'd5);
        wait_done("msub", 1'b0);
`else
        MDOp  = 4'd9;
        A     = 32'd5;
        B     = 32'd6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        MDOp  = 4'd0;
        chk("madd_off_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("madd_off_busy_later", busy, 0);
        chk("madd_off_lo", LO, m_lo);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
